bcd_to_bin_conv: RTL and testbench

//   Multi-cycle converter from packed BCD to unsigned binary (reverse double-dabble).

---
 rtl/bcd_to_bin_conv.sv | 138 +++++++++++++
 tb/tb_bcd_to_bin_conv.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin_conv.sv
// Multi-cycle packed-BCD to unsigned binary converter (reverse double-dabble).
// One shift/correct iteration per clock; start/done handshake with a busy flag.
// Optional feature: define BCD2BIN_DIGIT_CHECK_EN to flag operands holding a nibble > 9
// (err=1, bin_out=0, result one clock after accept). Without it err is tied low.
module bcd_to_bin_conv #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [4*DIGITS-1:0]   bcd_in_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [BIN_W-1:0]      bin_out_o,
  output logic                  err_o
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned SrW  = BcdW + BIN_W;
  localparam int unsigned CntW = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

  state_e            state_q, state_d;
  logic [SrW-1:0]    sr_q;
  logic [SrW-1:0]    sr_step;
  logic [CntW-1:0]   cnt_q;
  logic [BIN_W-1:0]  bin_q;
  logic              last_iter;
  logic              abort_bad;

`ifdef BCD2BIN_DIGIT_CHECK_EN
  logic bad_q;
  logic bcd_bad;
  logic err_q;

  // Flag any operand digit above 9 at the accept edge.
  always_comb begin
    bcd_bad = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd_in_i[4*i +: 4] > 4'd9) bcd_bad = 1'b1;
    end
  end

  assign abort_bad = bad_q;
`else
  assign abort_bad = 1'b0;
`endif

  // One iteration: shift right, then subtract 3 from every BCD nibble that is >= 8.
  always_comb begin
    logic [SrW-1:0] shifted;
    logic [3:0]     nib;
    shifted = sr_q >> 1;
    sr_step = shifted;
    for (int i = 0; i < int'(DIGITS); i++) begin
      nib = shifted[BIN_W + 4*i +: 4];
      if (nib >= 4'd8) sr_step[BIN_W + 4*i +: 4] = nib - 4'd3;
    end
  end

  assign last_iter = (cnt_q == CntW'(BIN_W - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_i) state_d = StConv;
      StConv:  if (last_iter || abort_bad) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    busy_o = (state_q != StIdle);
    done_o = (state_q == StDone);
  end

  // Datapath: load operand on accept, iterate in CONV, capture result on the last step.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q  <= '0;
      cnt_q <= '0;
      bin_q <= '0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
      bad_q <= 1'b0;
      err_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (start_i) begin
            sr_q  <= {bcd_in_i, {BIN_W{1'b0}}};
            cnt_q <= '0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
            bad_q <= bcd_bad;
`endif
          end
        end
        StConv: begin
          if (abort_bad) begin
            bin_q <= '0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
            err_q <= 1'b1;
`endif
          end else begin
            sr_q  <= sr_step;
            cnt_q <= cnt_q + CntW'(1);
            if (last_iter) begin
              bin_q <= sr_step[BIN_W-1:0];
`ifdef BCD2BIN_DIGIT_CHECK_EN
              err_q <= 1'b0;
`endif
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bin_out_o = bin_q;
`ifdef BCD2BIN_DIGIT_CHECK_EN
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_bin_conv.sv
// Scoreboard bench for bcd_to_bin_conv: stimulus pushes expected results, a monitor
// pops and compares on every done pulse.
module tb_bcd_to_bin_conv;

  localparam int unsigned Lat = 14;

  logic        clk;
  logic        reset;
  logic        start_i;
  logic [15:0] bcd_in_i;
  logic        busy_o;
  logic        done_o;
  logic [13:0] bin_out_o;
  logic        err_o;

  bcd_to_bin_conv #(.DIGITS(4), .BIN_W(14)) dut (
    .clk       (clk),
    .reset     (reset),
    .start_i   (start_i),
    .bcd_in_i  (bcd_in_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .bin_out_o (bin_out_o),
    .err_o     (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] bin;
    logic        err;
    logic        chk_bin;
    int          due;     // expected cycle index of done; -1 skips the latency check
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && done_o) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.chk_bin) check("bin_out", int'(bin_out_o), int'(e.bin));
        check("err", int'(err_o), int'(e.err));
        check("busy_in_done", int'(busy_o), 1);
        if (e.due >= 0) check("latency", cyc, e.due);
      end
    end
  end

  // Issue one accepted conversion and queue its expected result.
  task automatic start_conv(input logic [15:0] bcd, input logic [13:0] exp_bin,
                            input logic exp_err, input logic chk_bin, input int lat);
    exp_t e;
    @(negedge clk);
    start_i  = 1'b1;
    bcd_in_i = bcd;
    e.bin = exp_bin; e.err = exp_err; e.chk_bin = chk_bin; e.due = cyc + 1 + lat;
    sb.push_back(e);
    @(negedge clk);
    start_i = 1'b0;
    check("busy_after_accept", int'(busy_o), 1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy_o || sb.size() != 0) && n < budget);
    check("idle_timeout", int'(n >= budget), 0);
  endtask

  initial begin
    reset    = 1'b1;
    start_i  = 1'b0;
    bcd_in_i = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy_o), 0);
    check("rst_done", int'(done_o), 0);
    check("rst_bin",  int'(bin_out_o), 0);
    check("rst_err",  int'(err_o), 0);
    reset = 1'b0;

    // 1: all nines
    start_conv(16'h9999, 14'd9999, 1'b0, 1'b1, Lat);
    wait_idle(100);

    // 2: all zeros then 1234, plus a couple more patterns
    start_conv(16'h0000, 14'd0, 1'b0, 1'b1, Lat);
    wait_idle(100);
    start_conv(16'h1234, 14'd1234, 1'b0, 1'b1, Lat);
    wait_idle(100);
    start_conv(16'h5080, 14'd5080, 1'b0, 1'b1, Lat);
    wait_idle(100);

    // 3: start held high, three results of 42; busy low exactly one cycle between
    begin
      exp_t e;
      int   n_done = 0;
      int   n_low  = 0;
      int   n      = 0;
      e.bin = 14'd42; e.err = 1'b0; e.chk_bin = 1'b1; e.due = -1;
      @(negedge clk);
      start_i  = 1'b1;
      bcd_in_i = 16'h0042;
      e.due = cyc + 1 + Lat;
      sb.push_back(e);
      e.due = -1;
      sb.push_back(e);
      sb.push_back(e);
      while (n_done < 3 && n < 200) begin
        @(negedge clk);
        n++;
        if (!busy_o) n_low++;
        if (done_o) n_done++;
      end
      start_i = 1'b0;
      check("held_timeout", int'(n >= 200), 0);
      check("held_busy_low_cycles", n_low, 2);
      wait_idle(100);
    end

    // 4: start pulse while busy is ignored; operand sampled only at accept
    start_conv(16'h0500, 14'd500, 1'b0, 1'b1, Lat);
    repeat (3) @(negedge clk);
    bcd_in_i = 16'h0007;
    start_i  = 1'b1;
    @(negedge clk);
    start_i  = 1'b0;
    wait_idle(100);
    repeat (20) @(negedge clk);

    // 5: reset mid-conversion aborts with no done
    @(negedge clk);
    start_i  = 1'b1;
    bcd_in_i = 16'h8765;
    @(negedge clk);
    start_i  = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", int'(busy_o), 0);
    check("abort_done", int'(done_o), 0);
    check("abort_bin",  int'(bin_out_o), 0);
    check("abort_err",  int'(err_o), 0);
    repeat (20) @(negedge clk);
    start_conv(16'h0001, 14'd1, 1'b0, 1'b1, Lat);
    wait_idle(100);

    // 6: invalid digit
`ifdef BCD2BIN_DIGIT_CHECK_EN
    start_conv(16'h12A4, 14'd0, 1'b1, 1'b1, 1);
`else
    start_conv(16'h12A4, 14'd0, 1'b0, 1'b0, Lat);
`endif
    wait_idle(100);

    // valid conversion after an invalid one clears err
    start_conv(16'h0777, 14'd777, 1'b0, 1'b1, Lat);
    wait_idle(100);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "global timeout");
  end

endmodule
